clk_div_ctrl: RTL and testbench

//  Run-time programmable integer clock divider with controller: sequences start/stop and

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_if.sv | 28 ++
 rtl/clk_div_core.sv | 68 ++++++
 rtl/clk_div_ctrl.sv | 104 ++++++++++
 tb/tb_clk_div_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

    // Default width of the ratio and period counter.
    localparam int CNT_W_DEF = 8;

    // Smallest ratio that can be applied; anything below it is rejected.
    localparam int DIV_MIN = 2;

    // Controller states: stopped, running, and running-until-next-boundary.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } div_state_e;

endpackage

// File: rtl/clk_div_if.sv
// Ratio configuration handshake between the register block (master) and
// the divider controller (slave).
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, posedge/negedge output register pair
// and the end-of-period decode. The ratio is only ever changed by the
// controller at a period boundary, so the decode thresholds stay stable
// for a whole period.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cur_div,
    output logic             period_end,
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] high_start;
    logic             clk_p_reg;
    logic             clk_p_next;
    logic             clk_n_reg;

    // First count of the high phase: N - floor(N/2), so the low phase is
    // never shorter than the high phase.
    assign high_start = cur_div - (cur_div >> 1);

    // Last source cycle of the current output period.
    assign period_end = run && (cnt_reg == (cur_div - CNT_W'(1)));

    // Next count and next posedge-phase level; both collapse to zero at a
    // boundary and while stopped so clk_p always falls on a boundary.
    always_comb begin
        cnt_next   = '0;
        clk_p_next = 1'b0;
        if (run && !period_end) begin
            cnt_next   = cnt_reg + CNT_W'(1);
            clk_p_next = (cnt_next >= high_start);
        end
    end

    // Posedge register pair: counter and main phase of the output clock.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_reg   <= '0;
            clk_p_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            clk_p_reg <= clk_p_next;
        end
    end

    // Half-cycle-delayed copy of clk_p, only for odd ratios, stretching the
    // high phase by half a source cycle.
    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_n_reg <= 1'b0;
        end else begin
            clk_n_reg <= clk_p_reg & cur_div[0];
        end
    end

    // Both halves only rise while the other is already high or low in a
    // stable way, so the OR does not glitch.
    assign clk_out = clk_p_reg | clk_n_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: start/stop sequencing, a one-deep pending
// ratio register behind a valid/ready handshake, and rejection of illegal
// ratios. New ratios are applied only at period boundaries (or straight
// away when idle) so clk_out never glitches.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    clk_div_if.slave         cfg,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_active,
    output logic             period_tick,
    output logic             clk_out
);

    div_state_e       state_reg;
    logic             div_active_reg;
    logic [CNT_W-1:0] cur_div_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             pend_vld_reg;
    logic             cfg_err_reg;
    logic             period_end;
    logic             cfg_fire;
    logic             cfg_legal;

    assign cfg_fire  = cfg.cfg_valid && !pend_vld_reg;
    assign cfg_legal = (cfg.cfg_div >= CNT_W'(DIV_MIN));

    assign cfg.cfg_ready = !pend_vld_reg;
    assign cfg.cfg_err   = cfg_err_reg;
    assign cur_div       = cur_div_reg;
    assign div_active    = div_active_reg;
    assign period_tick   = period_end;

    // Run/stop sequencing; a stop request only takes effect at a boundary.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg      <= ST_IDLE;
            div_active_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        state_reg      <= ST_RUN;
                        div_active_reg <= 1'b1;
                    end
                end
                ST_RUN, ST_STOPPING: begin
                    if (period_end && !en) begin
                        state_reg      <= ST_IDLE;
                        div_active_reg <= 1'b0;
                    end else if (en) begin
                        state_reg      <= ST_RUN;
                        div_active_reg <= 1'b1;
                    end else begin
                        state_reg      <= ST_STOPPING;
                        div_active_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    div_active_reg <= 1'b0;
                end
            endcase
        end
    end

    // Ratio handshake and application. Accept and apply are exclusive
    // because a transfer needs the pending slot to be empty.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_div_reg  <= CNT_W'(DEF_DIV);
            pend_div_reg <= '0;
            pend_vld_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_fire && !cfg_legal;
            if (pend_vld_reg && (period_end || (state_reg == ST_IDLE))) begin
                cur_div_reg  <= pend_div_reg;
                pend_vld_reg <= 1'b0;
            end else if (cfg_fire && cfg_legal) begin
                pend_div_reg <= cfg.cfg_div;
                pend_vld_reg <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .run        (div_active_reg),
        .cur_div    (cur_div_reg),
        .period_end (period_end),
        .clk_out    (clk_out)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl. A phase-based reference model
// (position k within an N-cycle period) predicts every output each source
// cycle, and clk_out in both half cycles.
module tb_clk_div_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       en;
    logic [7:0] cur_div;
    logic       div_active;
    logic       period_tick;
    logic       clk_out;

    clk_div_if #(.CNT_W(8)) cfg_bus ();

    clk_div_ctrl #(
        .CNT_W   (8),
        .DEF_DIV (5)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .en          (en),
        .cfg         (cfg_bus),
        .cur_div     (cur_div),
        .div_active  (div_active),
        .period_tick (period_tick),
        .clk_out     (clk_out)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit m_active;
    int m_k;
    int m_n;
    int m_pend;
    bit m_pend_vld;
    bit m_err;
    bit m_tail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_k        = 0;
        m_n        = 5;
        m_pend     = 0;
        m_pend_vld = 1'b0;
        m_err      = 1'b0;
        m_tail     = 1'b0;
    endtask

    // High phase covers the last floor(N/2) cycles of each period.
    function automatic bit exp_high();
        return m_active && (m_k >= (m_n + 1) / 2);
    endfunction

    // Advance the model by one source clock using the inputs presented.
    task automatic model_edge();
        bit at_end;
        bit ready;
        at_end = m_active && (m_k == m_n - 1);
        ready  = !m_pend_vld;
        // An odd period keeps clk_out high half a cycle past its end.
        m_tail = at_end && (m_n % 2 == 1);
        if (m_pend_vld && (at_end || !m_active)) begin
            m_n        = m_pend;
            m_pend_vld = 1'b0;
        end
        m_err = 1'b0;
        if (cfg_bus.cfg_valid && ready) begin
            if (cfg_bus.cfg_div < 2) begin
                m_err = 1'b1;
            end else begin
                m_pend     = int'(cfg_bus.cfg_div);
                m_pend_vld = 1'b1;
            end
        end
        if (!m_active || at_end) begin
            m_active = en;
            m_k      = 0;
        end else begin
            m_k++;
        end
    endtask

    // One source cycle: model update at posedge, check both halves.
    task automatic step();
        @(posedge sys_clk);
        model_edge();
        #1;
        chk("clk_out_h1", clk_out, exp_high() || m_tail);
        chk("period_tick", period_tick, m_active && (m_k == m_n - 1));
        chk("div_active", div_active, m_active);
        chk("cur_div", cur_div, m_n);
        chk("cfg_ready", cfg_bus.cfg_ready, !m_pend_vld);
        chk("cfg_err", cfg_bus.cfg_err, m_err);
        @(negedge sys_clk);
        #1;
        chk("clk_out_h2", clk_out, exp_high());
        $display("t=%0t en=%0b k=%0d n=%0d clk_out=%0b tick=%0b ready=%0b err=%0b",
                 $time, en, m_k, m_n, clk_out, period_tick, cfg_bus.cfg_ready, cfg_bus.cfg_err);
    endtask

    // Offer one ratio for a single cycle once the slot is free.
    task automatic send(input int n);
        int guard;
        guard = 0;
        while (m_pend_vld && guard < 600) begin
            step();
            guard++;
        end
        chk("send_ready_timeout", m_pend_vld, 0);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'(n);
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int guard;
        int ext[6];
        ext = '{2, 3, 255, 4, 7, 2};

        sys_rst_n         = 1'b0;
        en                = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = 8'd0;
        model_reset();

        // Reset values.
        repeat (2) @(negedge sys_clk);
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_cur_div", cur_div, 5);
        chk("rst_cfg_ready", cfg_bus.cfg_ready, 1);
        chk("rst_cfg_err", cfg_bus.cfg_err, 0);
        chk("rst_div_active", div_active, 0);
        chk("rst_period_tick", period_tick, 0);
        sys_rst_n = 1'b1;
        repeat (2) step();

        // Default ratio 5.
        en = 1'b1;
        repeat (25) step();

        // Ratio 4 offered mid-period.
        guard = 0;
        while (!(m_active && m_k == 2) && guard < 50) begin
            step();
            guard++;
        end
        chk("wait_mid_period", m_k, 2);
        send(4);
        repeat (20) step();

        // Illegal ratios 0 and 1.
        send(0);
        step();
        send(1);
        repeat (5) step();

        // Stop requested at cnt=1 of a 7-cycle period.
        send(7);
        guard = 0;
        while (!(m_active && m_n == 7 && m_k == 1) && guard < 100) begin
            step();
            guard++;
        end
        chk("wait_n7_k1", m_k, 1);
        en = 1'b0;
        repeat (15) step();

        // Extreme and alternating-parity ratios.
        en = 1'b1;
        foreach (ext[i]) begin
            send(ext[i]);
            repeat (3 * ext[i] + 10) step();
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            cfg_bus.cfg_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0)
                cfg_bus.cfg_div = 8'($urandom_range(0, 1));
            else
                cfg_bus.cfg_div = 8'($urandom_range(2, 12));
            step();
        end
        cfg_bus.cfg_valid = 1'b0;

        // Reset while clk_out is high and a ratio is pending.
        en = 1'b1;
        send(12);
        guard = 0;
        while (!(m_active && m_n == 12 && m_k == 0) && guard < 100) begin
            step();
            guard++;
        end
        chk("wait_n12", m_n, 12);
        send(9);
        guard = 0;
        while (!(exp_high() && m_pend_vld) && guard < 30) begin
            step();
            guard++;
        end
        chk("pre_rst_clk_out", clk_out, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", clk_out, 0);
        chk("async_rst_div_active", div_active, 0);
        chk("async_rst_cfg_ready", cfg_bus.cfg_ready, 1);
        chk("async_rst_cur_div", cur_div, 5);
        model_reset();
        repeat (2) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (12) step();
        chk("post_rst_cur_div", cur_div, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
